// File: rtl/register_bank.sv
// Bank of 2**LOG_N_REGISTERS flop-based registers with a single write port,
// a combinational read-back mux and every register flattened onto chip_out.
module register_bank #(
   parameter int LOG_N_REGISTERS = 5,
   parameter int DATA_WIDTH      = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       wr,
   input  logic [LOG_N_REGISTERS-1:0]                 address,
   input  logic [DATA_WIDTH-1:0]                      data_in,
   output logic [(2**LOG_N_REGISTERS)*DATA_WIDTH-1:0] chip_out,
   output logic [DATA_WIDTH-1:0]                      data_out
);

   localparam int N = 2**LOG_N_REGISTERS;

   logic [DATA_WIDTH-1:0] regs_q [N];
   logic [DATA_WIDTH-1:0] regs_d [N];

   always_comb begin
      // NOTE: start from the held value so every path assigns regs_d; no latch.
      regs_d = regs_q;
      if (wr) begin
         regs_d[address] = data_in;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: a reset loop over the array is fine here; these are discrete
      // flops whose cleared value is visible on chip_out, not a RAM macro.
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking so all registers update together at the edge.
         regs_q <= regs_d;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_chip_out
      assign chip_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   // Read-back is a pure mux of the stored value, so no write-through.
   assign data_out = regs_q[address];

endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven bench for register_bank with a few hand sequences
// for reset priority, hold behaviour and unknown inputs while idle.
module tb_register_bank;

   localparam int LOGN = 5;
   localparam int DW   = 8;
   localparam int N    = 2**LOGN;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr;
   logic [LOGN-1:0] address;
   logic [DW-1:0]   data_in;
   logic [N*DW-1:0] chip_out;
   logic [DW-1:0]   data_out;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] model [N];

   typedef struct {
      string         name;
      logic          rst;
      logic          wr;
      logic [LOGN-1:0] addr;
      logic [DW-1:0] din;
      logic          chk_pre;
      logic [DW-1:0] exp_pre;
      logic [DW-1:0] exp_post;
   } vec_t;

   vec_t vecs[$];

   register_bank #(.LOG_N_REGISTERS(LOGN), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr),
      .address  (address),
      .data_in  (data_in),
      .chip_out (chip_out),
      .data_out (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [N*DW-1:0] act,
                        input logic [N*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N*DW-1:0] pack_model();
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = model[i];
      return r;
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; wr = v.wr; address = v.addr; data_in = v.din;
      #1;
      if (v.chk_pre) check({v.name, " pre"}, N*DW'(data_out), N*DW'(v.exp_pre));
      @(posedge clk);
      if (v.rst) begin
         for (int i = 0; i < N; i++) model[i] = '0;
      end else if (v.wr) begin
         model[v.addr] = v.din;
      end
      #1;
      check({v.name, " post"}, N*DW'(data_out), N*DW'(v.exp_post));
      check({v.name, " chip"}, chip_out, pack_model());
   endtask

   task automatic zero_sweep(input string name);
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         address = LOGN'(a);
         #1 check($sformatf("%s a=%0d", name, a), N*DW'(data_out), '0);
      end
      check({name, " chip"}, chip_out, '0);
   endtask

   initial begin
      logic [N*DW-1:0] snap;
      logic [N*DW-1:0] fill_exp;

      rst = 1'b0; wr = 1'b0; address = '0; data_in = '0;
      for (int i = 0; i < N; i++) model[i] = '0;

      // Initial reset, then every address must read zero.
      apply('{name:"reset", rst:1, wr:0, addr:0, din:8'h00,
              chk_pre:0, exp_pre:8'h00, exp_post:8'h00});
      @(negedge clk); rst = 1'b0;
      zero_sweep("reset_zero");

      for (int k = 0; k < N; k++)
         vecs.push_back('{name:$sformatf("fill%0d", k), rst:0, wr:1,
                          addr:LOGN'(k), din:DW'(k), chk_pre:1,
                          exp_pre:8'h00, exp_post:DW'(k)});
      for (int k = 0; k < N; k++)
         vecs.push_back('{name:$sformatf("read%0d", k), rst:0, wr:0,
                          addr:LOGN'(k), din:8'h5A, chk_pre:1,
                          exp_pre:DW'(k), exp_post:DW'(k)});
      vecs.push_back('{name:"wrap0", rst:0, wr:0, addr:0, din:8'h00,
                       chk_pre:1, exp_pre:8'h00, exp_post:8'h00});
      vecs.push_back('{name:"wr7_a5", rst:0, wr:1, addr:7, din:8'hA5,
                       chk_pre:1, exp_pre:8'h07, exp_post:8'hA5});
      vecs.push_back('{name:"read6", rst:0, wr:0, addr:6, din:8'hFF,
                       chk_pre:1, exp_pre:8'h06, exp_post:8'h06});
      vecs.push_back('{name:"read8", rst:0, wr:0, addr:8, din:8'hFF,
                       chk_pre:1, exp_pre:8'h08, exp_post:8'h08});
      vecs.push_back('{name:"read7", rst:0, wr:0, addr:7, din:8'h00,
                       chk_pre:1, exp_pre:8'hA5, exp_post:8'hA5});
      vecs.push_back('{name:"wr31_c3", rst:0, wr:1, addr:31, din:8'hC3,
                       chk_pre:1, exp_pre:8'h1F, exp_post:8'hC3});

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         if (i == N-1) begin
            for (int k = 0; k < N; k++) fill_exp[k*DW +: DW] = DW'(k);
            check("fill_chip", chip_out, fill_exp);
            check("fill_lsb", N*DW'(chip_out[7:0]), N*DW'(8'h00));
            check("fill_msb", N*DW'(chip_out[255:248]), N*DW'(8'h1F));
         end
      end

      // Unknown address/data while idle must not disturb anything.
      snap = pack_model();
      @(negedge clk); wr = 1'b0; address = 'x; data_in = 'x;
      @(posedge clk); #1 check("x_idle_chip", chip_out, snap);

      // Hold: toggling data_in and sweeping address with wr low.
      data_in = 8'h3C;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         address = LOGN'((c * 5) % N);
         data_in = ~data_in;
         @(posedge clk); #1;
         check($sformatf("hold%0d chip", c), chip_out, snap);
         check($sformatf("hold%0d dout", c), N*DW'(data_out),
               N*DW'(model[(c * 5) % N]));
      end

      // Reset beats a simultaneous write and wipes the filled bank.
      apply('{name:"rst_wr3", rst:1, wr:1, addr:3, din:8'hFF,
              chk_pre:1, exp_pre:8'h03, exp_post:8'h00});
      @(negedge clk); rst = 1'b0; wr = 1'b0;
      zero_sweep("rst_after_fill");

      apply('{name:"wr3_after_rst", rst:0, wr:1, addr:3, din:8'h3C,
              chk_pre:1, exp_pre:8'h00, exp_post:8'h3C});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
